// File: rtl/spike_rate_decoder_if.sv
// Signal bundle between a spike source/consumer and spike_rate_decoder.
// The master side drives the spike train and configuration. The slave side is the decoder.
interface spike_rate_decoder_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             spike_in;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] burst_thresh;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             burst;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;

  modport master (
    output spike_in, enable, window_len, burst_thresh,
    input  rate_out, rate_valid, burst, isi_out, isi_valid
  );

  modport slave (
    input  spike_in, enable, window_len, burst_thresh,
    output rate_out, rate_valid, burst, isi_out, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts rising edges of a spike train over programmable windows and reports rate/burst.
// Also measures the interval between the two most recent spike edges.
module spike_rate_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  spike_rate_decoder_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state_reg;
  logic             spike_d_reg;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] cyc_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [CNT_W-1:0] rate_reg;
  logic             rate_valid_reg;
  logic             burst_reg;
  logic [ISI_W-1:0] isi_t_reg;
  logic [ISI_W-1:0] isi_reg;
  logic             isi_valid_reg;
  logic             have_prev_reg;

  logic             spike_edge;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W-1:0] acc_next;
  logic [ISI_W:0]   isi_sum;
  logic [ISI_W-1:0] isi_t_next;
  logic             win_end;
  logic             start_ok;

  assign spike_edge = bus.spike_in & ~spike_d_reg;

  // One spare bit catches overflow so the counters clamp instead of wrapping.
  assign acc_sum    = {1'b0, acc_reg} + {{CNT_W{1'b0}}, spike_edge};
  assign acc_next   = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
  assign isi_sum    = {1'b0, isi_t_reg} + {{ISI_W{1'b0}}, 1'b1};
  assign isi_t_next = isi_sum[ISI_W] ? {ISI_W{1'b1}} : isi_sum[ISI_W-1:0];

  assign win_end  = (cyc_reg == (win_reg - {{(WIN_W-1){1'b0}}, 1'b1}));
  assign start_ok = bus.enable && (bus.window_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      spike_d_reg    <= 1'b0;
      win_reg        <= '0;
      cyc_reg        <= '0;
      acc_reg        <= '0;
      rate_reg       <= '0;
      rate_valid_reg <= 1'b0;
      burst_reg      <= 1'b0;
    end else begin
      spike_d_reg    <= bus.spike_in;
      rate_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            win_reg   <= bus.window_len;
            cyc_reg   <= '0;
            acc_reg   <= '0;
            state_reg <= COUNT;
          end
        end
        COUNT: begin
          // Window end has priority over abort so a final-cycle disable still reports.
          if (win_end) begin
            rate_reg       <= acc_next;
            burst_reg      <= (acc_next >= bus.burst_thresh);
            rate_valid_reg <= 1'b1;
            if (start_ok) begin
              win_reg <= bus.window_len;
              cyc_reg <= '0;
              acc_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else if (!bus.enable) begin
            state_reg <= IDLE;
          end else begin
            acc_reg <= acc_next;
            cyc_reg <= cyc_reg + {{(WIN_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The interval timer runs regardless of the window FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_t_reg     <= '0;
      isi_reg       <= '0;
      isi_valid_reg <= 1'b0;
      have_prev_reg <= 1'b0;
    end else begin
      isi_valid_reg <= 1'b0;
      if (spike_edge) begin
        isi_t_reg     <= {{(ISI_W-1){1'b0}}, 1'b1};
        have_prev_reg <= 1'b1;
        if (have_prev_reg) begin
          isi_reg       <= isi_t_reg;
          isi_valid_reg <= 1'b1;
        end
      end else begin
        isi_t_reg <= isi_t_next;
      end
    end
  end

  assign bus.rate_out   = rate_reg;
  assign bus.rate_valid = rate_valid_reg;
  assign bus.burst      = burst_reg;
  assign bus.isi_out    = isi_reg;
  assign bus.isi_valid  = isi_valid_reg;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: expected reports are queued when stimulus is driven
// and checked when the rate/isi valid pulses appear.
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) bus ();
  spike_rate_decoder_if #(.WIN_W(8), .CNT_W(4), .ISI_W(8)) bus2 ();

  spike_rate_decoder #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  spike_rate_decoder #(.WIN_W(8), .CNT_W(4), .ISI_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {int rate; int burst;} rexp_t;
  rexp_t rate_q[$];
  rexp_t sat_q[$];
  int    isi_q[$];
  int    rate_times[$];

  int vectors = 0;
  int miscompares = 0;

  // ISI reference: absolute sample index of the last edge
  int   tcnt = 0;
  int   m_last_t = 0;
  logic m_have_prev = 1'b0;
  logic m_prev_sp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the values are sampled at the following posedge.
  task automatic drive(input logic sp, input logic en);
    int d;
    @(negedge clk);
    rst_n = 1'b1;
    bus.spike_in = sp;
    bus.enable = en;
    tcnt++;
    if (sp && !m_prev_sp) begin
      if (m_have_prev) begin
        d = tcnt - m_last_t;
        isi_q.push_back(d > 255 ? 255 : d);
      end
      m_have_prev = 1'b1;
      m_last_t = tcnt;
    end
    m_prev_sp = sp;
  endtask

  task automatic start(input int len, input int thr);
    bus.window_len = 8'(len);
    bus.burst_thresh = 8'(thr);
    drive(1'b0, 1'b1);
  endtask

  task automatic body(input int len, input logic [63:0] pat, input logic last_en);
    for (int j = 1; j <= len; j++) drive(pat[j-1], (j == len) ? last_en : 1'b1);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b0);
  endtask

  task automatic drained(input string tag);
    check({tag, "_rate_q"}, rate_q.size(), 0);
    check({tag, "_isi_q"}, isi_q.size(), 0);
  endtask

  always begin : monitor
    rexp_t e;
    int    iv;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (bus.rate_valid === 1'b1) begin
        check("rate_pulse_expected", 32'(rate_q.size() != 0), 1);
        if (rate_q.size() != 0) begin
          e = rate_q.pop_front();
          check("rate_out", 32'(bus.rate_out), e.rate);
          check("burst", 32'(bus.burst), e.burst);
          rate_times.push_back(int'($time));
        end
      end
      if (bus.isi_valid === 1'b1) begin
        check("isi_pulse_expected", 32'(isi_q.size() != 0), 1);
        if (isi_q.size() != 0) begin
          iv = isi_q.pop_front();
          check("isi_out", 32'(bus.isi_out), iv);
        end
      end
      if (bus2.rate_valid === 1'b1) begin
        check("sat_pulse_expected", 32'(sat_q.size() != 0), 1);
        if (sat_q.size() != 0) begin
          e = sat_q.pop_front();
          check("sat_rate_out", 32'(bus2.rate_out), e.rate);
          check("sat_burst", 32'(bus2.burst), e.burst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    bus.spike_in = 1'b0;  bus.enable = 1'b0;  bus.window_len = '0;  bus.burst_thresh = '0;
    bus2.spike_in = 1'b0; bus2.enable = 1'b0; bus2.window_len = '0; bus2.burst_thresh = '0;

    // Reset held with a toggling spike train
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      bus.spike_in = ~bus.spike_in;
    end
    check("rst_rate_out", 32'(bus.rate_out), 0);
    check("rst_rate_valid", 32'(bus.rate_valid), 0);
    check("rst_burst", 32'(bus.burst), 0);
    check("rst_isi_out", 32'(bus.isi_out), 0);
    check("rst_isi_valid", 32'(bus.isi_valid), 0);
    check("rst_sat_rate_out", 32'(bus2.rate_out), 0);
    bus.spike_in = 1'b0;

    // Released with enable low, then enable high with window_len 0: no reports
    bus.window_len = 8'd10;
    idle(12);
    bus.window_len = 8'd0;
    for (int j = 0; j < 12; j++) drive(1'b0, 1'b1);
    idle(2);
    drained("no_window");

    // Basic: spikes on window cycles 2, 5, 8
    rate_q.push_back('{3, 0});
    start(10, 5);
    body(10, 64'h092, 1'b0);
    idle(4);
    drained("basic");

    // Level held high 5 cycles counts once
    rate_q.push_back('{1, 0});
    start(10, 5);
    body(10, 64'h07C, 1'b0);
    idle(4);
    drained("level");

    // Edge on the last window cycle belongs to that window
    rate_q.push_back('{1, 0});
    rate_q.push_back('{0, 0});
    start(10, 5);
    body(10, 64'h200, 1'b1);
    body(10, 64'h000, 1'b0);
    idle(4);
    drained("last_cycle");

    // Back-to-back 8-cycle windows with burst threshold 3
    rate_q.push_back('{3, 1});
    rate_q.push_back('{2, 0});
    n0 = rate_times.size();
    start(8, 3);
    body(8, 64'h15, 1'b1);
    body(8, 64'h22, 1'b0);
    idle(4);
    drained("b2b");
    check("b2b_spacing", 32'(rate_times[n0+1] - rate_times[n0]), 80);

    // Abort at window cycle 4: report suppressed, previous rate kept
    start(10, 5);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    idle(15);
    drained("abort");
    check("abort_rate_hold", 32'(bus.rate_out), 2);
    check("abort_burst_hold", 32'(bus.burst), 0);

    // Reset in the middle of a window after two spikes
    start(10, 5);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    m_have_prev = 1'b0;
    m_prev_sp = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rate_out", 32'(bus.rate_out), 0);
    check("midrst_isi_out", 32'(bus.isi_out), 0);
    check("midrst_rate_valid", 32'(bus.rate_valid), 0);
    rate_q.push_back('{1, 0});
    start(10, 5);
    body(10, 64'h008, 1'b0);
    idle(4);
    drained("midrst");

    // Saturation on the 4-bit counter instance: 20 edges in 40 cycles
    sat_q.push_back('{15, 1});
    bus2.window_len = 8'd40;
    bus2.burst_thresh = 4'd15;
    @(negedge clk);
    bus2.enable = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      bus2.spike_in = (j % 2 == 1);
      bus2.enable = (j != 40);
    end
    @(negedge clk);
    bus2.spike_in = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_q_drained", sat_q.size(), 0);
    drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
